main_memory_arbiter: RTL
========================

// Module: main_memory_arbiter
// PURPOSE
//  Shares the single main-memory port (8-bit address, 16-bit data) between two requesters:
//  port 0 = core MemoryAccess stage, port 1 = loader/debug master.
//  Registers each accepted command, sequences the write or fixed-latency read, and returns read data.
//  Raises stall_core while a core request waits, so the pipeline can freeze.
//  Sits between Core's memory-access path and the main-memory tristate bus driver.
// PARAMETERS
//  ADDR_W         8  memory address width
//  DATA_W         16 memory data width
//  READ_LAT       1  cycles from address presented to mem_rdata valid (>=1)
//  CORE_PRIORITY  1  1 = fixed core priority with anti-starvation; 0 = strict round-robin
//  MAX_CORE_BURST 4  consecutive core grants allowed while port 1 waits (CORE_PRIORITY=1 only)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset        in   1       asynchronous, active-high
//  req0_valid   in   1       core request present
//  req0_we      in   1       1 = write, 0 = read
//  req0_addr    in   ADDR_W  core address
//  req0_wdata   in   DATA_W  core write data
//  req0_ready   out  1       core request accepted this cycle (valid & ready)
//  req0_rvalid  out  1       one-cycle pulse, req0_rdata valid
//  req0_rdata   out  DATA_W  core read data
//  req1_*       same set as req0_* for loader/debug port
//  stall_core   out  1       req0_valid & ~req0_ready
//  mem_addr     out  ADDR_W  registered address to memory
//  mem_we       out  1       write strobe to memory
//  mem_oe       out  1       drive enable for the tristate data bus (writes only)
//  mem_wdata    out  DATA_W  data driven onto bus when mem_oe=1
//  mem_rdata    in   DATA_W  data sampled from bus
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, starv_cnt=0, last_grant=1 (core wins first tie).
//   Reset mid-operation aborts the command: mem_we/mem_oe drop immediately, no rvalid issued.
//  FSM states IDLE, WRITE, READ, RESP.
//  IDLE:
//   reqX_ready is combinational, asserted only in IDLE for the granted port.
//   Accept cycle N: latch addr/we/wdata/port; go to WRITE if we, else READ.
//  WRITE (cycle N+1):
//   mem_addr/mem_wdata driven, mem_we=1, mem_oe=1 for exactly one cycle; then IDLE.
//   No response pulse for writes. Throughput: 1 write per 2 cycles.
//  READ (cycles N+1 .. N+READ_LAT):
//   mem_addr held, mem_we=0, mem_oe=0; lat_cnt counts down from READ_LAT-1.
//   mem_rdata sampled into data register at end of cycle N+READ_LAT; go to RESP.
//  RESP (cycle N+READ_LAT+1):
//   reqX_rvalid=1 for latched port, reqX_rdata=sampled data; always go to IDLE next.
//   No ready asserted in RESP.
//   reqX_rdata holds last value after rvalid; the other port's rvalid stays 0.
//  Arbitration in IDLE, both valid:
//   CORE_PRIORITY=1: grant core, unless starv_cnt==MAX_CORE_BURST, then grant port 1.
//   starv_cnt increments on each core grant while req1_valid=1.
//   starv_cnt clears on a port-1 grant or any cycle req1_valid=0.
//   Saturates at MAX_CORE_BURST.
//   CORE_PRIORITY=0: grant port != last_grant; last_grant updates on every accept.
//   Single valid: grant it regardless of mode.
//  Requesters must hold valid/we/addr/wdata stable until ready; dropping valid early is legal (no accept).
//  Addresses pass unmodified (ADDR_W wide); no wrap or translation.
// TESTING
//  1. Reset, then core write addr 0x12 data 0xBEEF -> req0_ready at N; N+1 mem_we=1, mem_oe=1,
//     mem_addr=0x12, mem_wdata=0xBEEF; N+2 idle.
//  2. Core read 0x12, memory model returns 0xBEEF, READ_LAT=1 -> req0_rvalid=1,
//     req0_rdata=0xBEEF at N+2; req1_rvalid stays 0.
//  3. Both ports issue back-to-back reads continuously, CORE_PRIORITY=1, MAX_CORE_BURST=4
//     -> grant order 0,0,0,0,1,0,0,0,0,1.
//  4. Same stimulus, CORE_PRIORITY=0 -> grants alternate 0,1,0,1;
//     stall_core=1 in every cycle the core waits.
//  5. READ_LAT=3 read, then assert reset in the second READ cycle
//     -> all outputs 0 immediately, no rvalid; next request accepted normally after release.
//  6. Port 1 write to 0xFF followed by core read of 0xFF -> core reads the new data
//     (ordering preserved, wrap-free top address).

Source files
------------

// File: rtl/main_memory_arbiter.sv
// Two-port arbiter for a single main-memory port: core (port 0) and loader/debug (port 1).
// One command is in flight at a time. Writes take one bus cycle. Reads wait a fixed latency, then return data.
module main_memory_arbiter #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int READ_LAT       = 1,
  parameter int CORE_PRIORITY  = 1,
  parameter int MAX_CORE_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              stall_core,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

  localparam int LAT_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int STARV_W = (MAX_CORE_BURST > 0) ? $clog2(MAX_CORE_BURST + 1) : 1;
  localparam logic [LAT_W-1:0]   LAT_INIT  = LAT_W'(READ_LAT - 1);
  localparam logic [STARV_W-1:0] STARV_MAX = STARV_W'(MAX_CORE_BURST);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                port_q, port_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [STARV_W-1:0]  starv_q, starv_d;
  logic                last_grant_q, last_grant_d;
  logic                grant1;
  logic                accept;

  // Arbitration decision, meaningful only when accept is high.
  always_comb begin
    grant1 = req1_valid;
    if (req0_valid && req1_valid) begin
      if (CORE_PRIORITY != 0) grant1 = (starv_q == STARV_MAX);
      else                    grant1 = ~last_grant_q;
    end
  end

  assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
  // Reset also gates the combinational handshake outputs, so every output reads 0 while reset is held.
  assign req0_ready = accept && !grant1 && !reset;
  assign req1_ready = accept &&  grant1 && !reset;
  assign stall_core = req0_valid && !req0_ready && !reset;

  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = (state_q == WRITE);
  assign mem_oe      = (state_q == WRITE);
  assign req0_rvalid = (state_q == RESP) && !port_q;
  assign req1_rvalid = (state_q == RESP) &&  port_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    port_d       = port_q;
    lat_d        = lat_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: if (accept) begin
        port_d       = grant1;
        last_grant_d = grant1;
        addr_d       = grant1 ? req1_addr  : req0_addr;
        wdata_d      = grant1 ? req1_wdata : req0_wdata;
        lat_d        = LAT_INIT;
        state_d      = (grant1 ? req1_we : req0_we) ? WRITE : READ;
      end
      WRITE: state_d = IDLE;
      READ: begin
        if (lat_q == '0) begin
          if (port_q) rdata1_d = mem_rdata;
          else        rdata0_d = mem_rdata;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starvation counter: core grants in a row while port 1 is kept waiting.
  always_comb begin
    starv_d = starv_q;
    if (!req1_valid)                                starv_d = '0;
    else if (accept && grant1)                      starv_d = '0;
    else if (accept && !grant1 && starv_q != STARV_MAX) starv_d = starv_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      port_q       <= 1'b0;
      lat_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      starv_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      port_q       <= port_d;
      lat_q        <= lat_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      starv_q      <= starv_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule
